// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: MSB-first bit pairs in, {gt, eq, lt} out.
// Optional EARLY_DONE_EN: finish on the first differing bit pair instead of after W pairs.
module serial_mag_comp #(
    parameter int unsigned W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_valid,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       ready,
    output logic       done,
    output logic [2:0] x
);

    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            decided;
    logic            decided_next;
    logic [2:0]      res;
    logic [2:0]      res_next;
    logic [2:0]      x_next;
    logic            done_next;
    logic            ready_next;
    logic            differ;
    logic            last_pair;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        decided_next = decided;
        res_next     = res;
        x_next       = x;
        done_next    = 1'b0;
        differ       = a_bit ^ b_bit;
        last_pair    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = SHIFT;
                    cnt_next     = '0;
                    decided_next = 1'b0;
                    res_next     = RES_NONE;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    cnt_next = cnt + CW'(1);
                    // First differing pair (MSB first) fixes the result for good
                    if (!decided && differ) begin
                        res_next     = a_bit ? RES_GT : RES_LT;
                        decided_next = 1'b1;
                    end
                    last_pair = (cnt == CW'(W - 1));
`ifdef EARLY_DONE_EN
                    if (!decided && differ) begin
                        last_pair = 1'b1;
                    end
`endif
                    if (last_pair) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        x_next     = decided_next ? res_next : RES_EQ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == SHIFT);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            decided <= 1'b0;
            res     <= RES_NONE;
            x       <= RES_NONE;
            done    <= 1'b0;
            ready   <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            decided <= decided_next;
            res     <= res_next;
            x       <= x_next;
            done    <= done_next;
            ready   <= ready_next;
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp: a W=2 and a W=8 instance on a shared clock/reset.
// Expected latencies follow EARLY_DONE_EN when it is defined.
module tb_serial_mag_comp;

    logic       clk = 1'b0;
    logic       rst;

    logic       s2, v2, a2, b2, r2, d2;
    logic [2:0] x2;
    logic       s8, v8, a8, b8, r8, d8;
    logic [2:0] x8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_mag_comp #(.W(2)) dut2 (
        .clk(clk), .rst(rst), .start(s2), .bit_valid(v2), .a_bit(a2), .b_bit(b2),
        .ready(r2), .done(d2), .x(x2)
    );

    serial_mag_comp #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .bit_valid(v8), .a_bit(a8), .b_bit(b8),
        .ready(r8), .done(d8), .x(x8)
    );

    // Cycles from start to done for a stall-free or stalled compare
    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b,
                                   input int w, input int stalls);
`ifdef EARLY_DONE_EN
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return w - i + 1;
        end
`endif
        return w + 1 + stalls;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b,
                        input logic [2:0] ex, input string nm);
        int idx = 1;
        int lat = 0;
        bit got = 1'b0;
        int el = exp_lat({6'd0, a}, {6'd0, b}, 2, 0);
        s2 = 1'b1;
        for (int c = 1; c <= 20 && !got; c++) begin
            step();
            s2 = 1'b0;
            if (d2) begin
                got = 1'b1;
                lat = c;
                v2 = 1'b0;
            end else if (r2 && idx >= 0) begin
                v2 = 1'b1;
                a2 = a[idx];
                b2 = b[idx];
                idx--;
            end else begin
                v2 = 1'b0;
            end
        end
        checks++;
        if (!got || lat != el) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", nm, lat, got, el);
        end
        checks++;
        if (x2 !== ex) begin
            errors++;
            $display("FAIL %s x: got %b expected %b", nm, x2, ex);
        end
        step();
        checks++;
        if (d2 !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: got %b expected 0", nm, d2);
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ex,
                        input int stall_at, input int stall_len, input string nm);
        int sent = 0;
        int stalled = 0;
        int lat = 0;
        int drops = 0;
        bit got = 1'b0;
        int el = exp_lat(a, b, 8, stall_len);
        s8 = 1'b1;
        for (int c = 1; c <= 40 && !got; c++) begin
            step();
            s8 = 1'b0;
            if (d8) begin
                got = 1'b1;
                lat = c;
                v8 = 1'b0;
                checks++;
                if (r8 !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_at_done: got %b expected 0", nm, r8);
                end
            end else if (!r8) begin
                drops++;
                v8 = 1'b0;
            end else if (sent < 8) begin
                if (sent == stall_at && stalled < stall_len) begin
                    v8 = 1'b0;
                    stalled++;
                end else begin
                    v8 = 1'b1;
                    a8 = a[7 - sent];
                    b8 = b[7 - sent];
                    sent++;
                end
            end else begin
                v8 = 1'b0;
            end
        end
        checks++;
        if (!got || lat != el) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", nm, lat, got, el);
        end
        checks++;
        if (x8 !== ex) begin
            errors++;
            $display("FAIL %s x: got %b expected %b", nm, x8, ex);
        end
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL %s ready_drop: got %0d low cycles expected 0", nm, drops);
        end
        step();
        checks++;
        if (r8 !== 1'b0 || d8 !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got ready=%b done=%b expected 0 0", nm, r8, d8);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (x2 !== 3'b000 || x8 !== 3'b000) begin
            errors++;
            $display("FAIL reset_x: got %b/%b expected 000/000", x2, x8);
        end
        checks++;
        if (d2 !== 1'b0 || d8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b/%b expected 0/0", d2, d8);
        end
        checks++;
        if (r2 !== 1'b0 || r8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b/%b expected 0/0", r2, r8);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_compare_w2();
        run2(2'b11, 2'b00, 3'b100, "w2_11_00");
        run2(2'b11, 2'b01, 3'b100, "w2_11_01");
        run2(2'b10, 2'b01, 3'b100, "w2_10_01");
        run2(2'b11, 2'b11, 3'b010, "w2_11_11");
        run2(2'b00, 2'b00, 3'b010, "w2_00_00");
        run2(2'b00, 2'b10, 3'b001, "w2_00_10");
        run2(2'b01, 2'b10, 3'b001, "w2_01_10");
        run2(2'b00, 2'b11, 3'b001, "w2_00_11");
    endtask

    task automatic test_stall_w8();
        run8(8'h80, 8'h7F, 3'b100, 4, 3, "w8_stall");
    endtask

    task automatic test_reset_mid();
        s2 = 1'b1;
        step();
        s2 = 1'b0;
        checks++;
        if (r2 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid ready_before: got %b expected 1", r2);
        end
        v2 = 1'b1;
        a2 = 1'b0;
        b2 = 1'b0;
        step();
        rst = 1'b1;
        a2 = 1'b1;
        b2 = 1'b0;
        checks++;
        if (d2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid done_pre: got %b expected 0", d2);
        end
        step();
        checks++;
        if (x2 !== 3'b000 || r2 !== 1'b0 || d2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid state: got x=%b ready=%b done=%b expected 000 0 0", x2, r2, d2);
        end
        rst = 1'b0;
        v2 = 1'b0;
        step();
        checks++;
        if (d2 !== 1'b0 || r2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid idle: got done=%b ready=%b expected 0 0", d2, r2);
        end
        run2(2'b10, 2'b01, 3'b100, "after_rst");
    endtask

    task automatic test_back_to_back();
        int exp_c[3] = '{3, 7, 11};
        int k = 0;
        int idx = 1;
        logic [1:0] a = 2'b01;
        logic [1:0] b = 2'b01;
        s2 = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (d2) begin
                checks++;
                if (k >= 3 || c != exp_c[k]) begin
                    errors++;
                    $display("FAIL b2b pulse%0d cycle: got %0d expected %0d", k, c,
                             (k < 3) ? exp_c[k] : -1);
                end
                checks++;
                if (x2 !== 3'b010) begin
                    errors++;
                    $display("FAIL b2b pulse%0d x: got %b expected 010", k, x2);
                end
                k++;
                idx = 1;
                v2 = 1'b0;
            end else if (r2 && idx >= 0) begin
                v2 = 1'b1;
                a2 = a[idx];
                b2 = b[idx];
                idx--;
            end else begin
                v2 = 1'b0;
            end
        end
        s2 = 1'b0;
        v2 = 1'b0;
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL b2b pulse_count: got %0d expected 3", k);
        end
        step();
        step();
    endtask

    task automatic test_early_done();
        run8(8'h40, 8'h00, 3'b100, 8, 0, "w8_bit6");
    endtask

    initial begin
        rst = 1'b1;
        s2 = 1'b0; v2 = 1'b0; a2 = 1'b0; b2 = 1'b0;
        s8 = 1'b0; v8 = 1'b0; a8 = 1'b0; b8 = 1'b0;
        repeat (3) step();
        test_reset();
        test_compare_w2();
        test_stall_w8();
        test_reset_mid();
        test_back_to_back();
        test_early_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
